// File: rtl/fp_add_norm_pipe_pkg.sv
// Shared FP definitions for the adder post-normalisation path:
// default widths, FP16 special values, rounding-mode encodings and
// the stage-1 to stage-2 payload layout.
package fp_add_norm_pipe_pkg;

    localparam int unsigned DEF_EW   = 5;
    localparam int unsigned DEF_MW   = 10;
    localparam int unsigned DEF_BIAS = (1 << (DEF_EW - 1)) - 1;

    localparam logic [15:0] FP16_POS_INF  = 16'h7C00;
    localparam logic [15:0] FP16_NEG_INF  = 16'hFC00;
    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
    localparam logic [15:0] FP16_NEG_ZERO = 16'h8000;

    typedef enum logic {
        RND_RNE   = 1'b0,
        RND_TRUNC = 1'b1
    } rnd_mode_e;

    // Normalised payload handed from S1 to S2 (default FP16 widths).
    // exp carries one extra bit so carry/round overflow past all-ones is visible.
    typedef struct packed {
        logic              sign;
        logic [DEF_EW:0]   exp;
        logic [DEF_MW-1:0] frac;
        logic              g;
        logic              r;
        logic              s;
        logic              zero;
        logic              uf;
        rnd_mode_e         rnd;
    } fp16_s1_t;

    function automatic int unsigned exp_bias(input int unsigned ew);
        return (1 << (ew - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_add_norm_pipe_lzc.sv
// Parametrised priority leading-zero counter (combinational).
// cnt = number of zeros above the most significant set bit; W when all zero.
module fp_lzc #(
    parameter int unsigned W = 14,
    localparam int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  in_bits,
    output logic [CW-1:0] cnt,
    output logic          all_zero
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        cnt = CW'(W);
        for (int unsigned i = 0; i < W; i++) begin
            if (in_bits[i]) begin
                cnt = CW'(W - 1 - i);
            end
        end
    end

    assign all_zero = ~|in_bits;

endmodule

// File: rtl/fp_add_norm_pipe.sv
// Pipelined post-add normaliser/rounder for the FP adder path.
// S1 renormalises the raw signed-magnitude sum, S2 rounds and packs.
// Two-deep valid/ready pipeline, one beat per cycle, order preserved.
module fp_add_norm_pipe
    import fp_add_norm_pipe_pkg::*;
#(
    parameter int unsigned EW = DEF_EW,
    parameter int unsigned MW = DEF_MW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_sign,
    input  logic [EW-1:0]  in_exp,
    input  logic [MW+4:0]  in_mant,
    input  logic           in_rnd,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [EW+MW:0] out_result,
    output logic           out_ovf,
    output logic           out_uf,
    output logic           out_inexact
);

    // Hidden bit down to sticky bit.
    localparam int unsigned NW  = MW + 4;
    localparam int unsigned LZW = $clog2(NW + 1);
    localparam logic [EW:0] EXP_MAX = (EW + 1)'((1 << EW) - 1);

    // Same layout as the package payload, sized by this instance's parameters.
    typedef struct packed {
        logic          sign;
        logic [EW:0]   exp;
        logic [MW-1:0] frac;
        logic          g;
        logic          r;
        logic          s;
        logic          zero;
        logic          uf;
        rnd_mode_e     rnd;
    } s1_payload_t;

    logic           ready_en;
    logic           s1_valid;
    logic           s1_adv;
    logic           s2_adv;
    logic           accept;
    s1_payload_t    s1_d;
    s1_payload_t    s1_q;
    logic [LZW-1:0] lz_cnt;
    logic           lz_zero;
    logic [NW-1:0]  norm_mant;

    logic           round_up;
    logic [MW:0]    frac_sum;
    logic [EW:0]    exp_rnd;
    logic           ovf_d;
    logic           inexact_d;
    logic [EW+MW:0] result_d;

    fp_lzc #(.W(NW)) u_lzc (
        .in_bits  (in_mant[NW-1:0]),
        .cnt      (lz_cnt),
        .all_zero (lz_zero)
    );

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = ready_en && s1_adv;
    assign accept   = in_valid && in_ready;

    // S1: carry renormalise, zero detect, underflow flush or left normalise.
    always_comb begin
        s1_d      = '0;
        s1_d.sign = in_sign;
        s1_d.rnd  = rnd_mode_e'(in_rnd);
        norm_mant = in_mant[NW-1:0] << lz_cnt;
        if (in_mant[NW]) begin
            s1_d.exp  = {1'b0, in_exp} + (EW + 1)'(1);
            s1_d.frac = in_mant[NW-1:4];
            s1_d.g    = in_mant[3];
            s1_d.r    = in_mant[2];
            s1_d.s    = |in_mant[1:0];
        end else if (lz_zero) begin
            s1_d.zero = 1'b1;
        end else if (32'(lz_cnt) >= 32'(in_exp)) begin
            s1_d.uf = 1'b1;
        end else begin
            s1_d.exp  = {1'b0, in_exp} - (EW + 1)'(lz_cnt);
            s1_d.frac = norm_mant[NW-2:3];
            s1_d.g    = norm_mant[2];
            s1_d.r    = norm_mant[1];
            s1_d.s    = norm_mant[0];
        end
    end

    // S2: rounding increment, overflow saturation to Inf, result packing.
    always_comb begin
        round_up  = (s1_q.rnd == RND_RNE) && s1_q.g && (s1_q.r || s1_q.s || s1_q.frac[0]);
        frac_sum  = {1'b0, s1_q.frac} + (MW + 1)'(round_up);
        exp_rnd   = s1_q.exp + (EW + 1)'(frac_sum[MW]);
        ovf_d     = !s1_q.zero && !s1_q.uf && (exp_rnd >= EXP_MAX);
        inexact_d = s1_q.g || s1_q.r || s1_q.s;
        if (s1_q.zero || s1_q.uf) begin
            result_d = {s1_q.sign, {(EW + MW){1'b0}}};
        end else if (ovf_d) begin
            result_d = {s1_q.sign, EXP_MAX[EW-1:0], {MW{1'b0}}};
        end else begin
            result_d = {s1_q.sign, exp_rnd[EW-1:0], frac_sum[MW-1:0]};
        end
    end

    // Input acceptance is held off until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // S1 register: loads a new beat whenever S1 can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_q <= s1_d;
            end
        end
    end

    // S2/output register: holds while stalled, flags cleared on bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_ovf     <= 1'b0;
            out_uf      <= 1'b0;
            out_inexact <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result  <= result_d;
                out_ovf     <= ovf_d;
                out_uf      <= s1_q.uf;
                out_inexact <= inexact_d;
            end else begin
                out_result  <= '0;
                out_ovf     <= 1'b0;
                out_uf      <= 1'b0;
                out_inexact <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_norm_pipe.sv
// Scoreboard bench for fp_add_norm_pipe (FP16 defaults).
// Driver pushes hand-computed expectations on acceptance; a monitor
// pops and compares whenever a result transfers.
module tb_fp_add_norm_pipe;
    import fp_add_norm_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [4:0]  in_exp = '0;
    logic [14:0] in_mant = '0;
    logic        in_rnd = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic        out_ovf;
    logic        out_uf;
    logic        out_inexact;

    fp_add_norm_pipe #(.EW(5), .MW(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_mant     (in_mant),
        .in_rnd      (in_rnd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_ovf     (out_ovf),
        .out_uf      (out_uf),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic        ovf;
        logic        uf;
        logic        inx;
    } exp_t;

    typedef struct {
        logic        s;
        logic [4:0]  e;
        logic [14:0] m;
        logic        r;
        logic [15:0] res;
        logic        ovf;
        logic        uf;
        logic        inx;
    } vec_t;

    vec_t vecs [17] = '{
        '{1'b0, 5'd15, 15'h4000, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b0},
        '{1'b0, 5'd15, 15'h1000, 1'b0, 16'h3800, 1'b0, 1'b0, 1'b0},
        '{1'b0, 5'd15, 15'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0},
        '{1'b0, 5'd15, 15'h2004, 1'b0, 16'h3C00, 1'b0, 1'b0, 1'b1},
        '{1'b0, 5'd15, 15'h200C, 1'b0, 16'h3C02, 1'b0, 1'b0, 1'b1},
        '{1'b0, 5'd15, 15'h200C, 1'b1, 16'h3C01, 1'b0, 1'b0, 1'b1},
        '{1'b0, 5'd30, 15'h4000, 1'b0, 16'h7C00, 1'b1, 1'b0, 1'b0},
        '{1'b0, 5'd30, 15'h3FFC, 1'b0, 16'h7C00, 1'b1, 1'b0, 1'b1},
        '{1'b1, 5'd1,  15'h1000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0},
        '{1'b0, 5'd15, 15'h4001, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b1},
        '{1'b0, 5'd15, 15'h4018, 1'b0, 16'h4002, 1'b0, 1'b0, 1'b1},
        '{1'b1, 5'd20, 15'h0800, 1'b0, 16'hC800, 1'b0, 1'b0, 1'b0},
        '{1'b0, 5'd3,  15'h0800, 1'b0, 16'h0400, 1'b0, 1'b0, 1'b0},
        '{1'b0, 5'd2,  15'h0800, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0},
        '{1'b0, 5'd20, 15'h0001, 1'b0, 16'h1C00, 1'b0, 1'b0, 1'b0},
        '{1'b1, 5'd31, 15'h2000, 1'b0, 16'hFC00, 1'b1, 1'b0, 1'b0},
        '{1'b1, 5'd15, 15'h0000, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0}
    };

    exp_t exp_q [$];
    int   total = 0;
    int   bad = 0;
    int   n_accepted = 0;
    int   first_stall = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compare each transferring result, and check stability while stalled.
    logic        hold_valid = 1'b0;
    logic [18:0] hold_val = '0;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check("hold_stable", {12'd0, out_valid, out_result, out_ovf, out_uf, out_inexact},
                      {12'd0, 1'b1, hold_val});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %0h want none", out_result);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result",  {16'd0, out_result}, {16'd0, mon_e.res});
                    check("ovf",     {31'd0, out_ovf},     {31'd0, mon_e.ovf});
                    check("uf",      {31'd0, out_uf},      {31'd0, mon_e.uf});
                    check("inexact", {31'd0, out_inexact}, {31'd0, mon_e.inx});
                end
            end
            hold_valid = out_valid && !out_ready;
            hold_val   = {out_result, out_ovf, out_uf, out_inexact};
        end
    end

    task automatic send(input vec_t v);
        int tries = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_sign  = v.s;
        in_exp   = v.e;
        in_mant  = v.m;
        in_rnd   = v.r;
        @(negedge clk);
        while (!in_ready && tries < 20) begin
            if (first_stall < 0) first_stall = n_accepted;
            tries++;
            @(negedge clk);
        end
        if (in_ready) begin
            exp_q.push_back('{v.res, v.ovf, v.uf, v.inx});
            n_accepted++;
        end else begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready stuck at 0, wanted 1");
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_result", {16'd0, out_result}, 0);
        check("rst_flags", {29'd0, out_ovf, out_uf, out_inexact}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_before_clk", {31'd0, in_ready}, 0);
        @(negedge clk);
        check("in_ready_after_clk", {31'd0, in_ready}, 1);

        // Two-cycle latency on the carry case.
        send(vecs[0]);
        idle();
        check("latency_cycle1", {31'd0, out_valid}, 0);
        @(posedge clk);
        #1;
        check("latency_cycle2", {31'd0, out_valid}, 1);
        drain();

        // Directed vectors, back to back.
        for (int i = 0; i < 17; i++) send(vecs[i]);
        idle();
        drain();

        // Back-pressure: out_ready low for several cycles across 4 beats.
        first_stall = -1;
        n_accepted  = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        fork
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join_none
        send(vecs[1]);
        send(vecs[4]);
        send(vecs[11]);
        send(vecs[10]);
        idle();
        drain();
        check("stall_after_two", first_stall, 2);
        check("accepted_four", n_accepted, 4);

        // Reset mid-stream discards in-flight beats.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(vecs[3]);
        send(vecs[7]);
        idle();
        check("pre_reset_valid", {31'd0, out_valid}, 1);
        rst_n = 1'b0;
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(vecs[12]);
        idle();
        drain();
        repeat (6) @(posedge clk);
        #1;
        check("no_stale_output", {31'd0, out_valid}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
